// File: rtl/lab_counter_pkg.sv
// Shared constants and helpers for the lab board counter family.
// The up counter imports this package, and the down counter shares it.
package lab_counter_pkg;

  localparam int unsigned CNT_WIDTH      = 4;
  localparam int unsigned BOARD_DIV_BITS = 26;
  localparam int unsigned SIM_DIV_BITS   = 2;
  localparam int unsigned BCD_MAX        = 9;

  // Saturate rather than truncate so BCD digits never hold an illegal value.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one enabled-cycle tick every 2^DIV_BITS enabled clocks.
module tick_gen
  import lab_counter_pkg::*;
#(
  parameter int unsigned DIV_BITS = BOARD_DIV_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [DIV_BITS-1:0] div_cnt;

  // A clear realigns the prescaler phase even when en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + DIV_BITS'(1);
    end
  end

  assign tick = en && (div_cnt == '1);

endmodule

// File: rtl/sync_up_counter.sv
// Modulo-(MAX_COUNT+1) up counter advanced by prescaler ticks, with clear,
// clamped parallel load, terminal-count flag and a registered wrap carry.
module sync_up_counter
  import lab_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = CNT_WIDTH,
  parameter int unsigned DIV_BITS  = BOARD_DIV_BITS,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic             tick,
  output logic             tc,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] load_q;
  logic             at_max;

  tick_gen #(
    .DIV_BITS(DIV_BITS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .tick(tick)
  );

  assign load_q = WIDTH'(clamp_load(32'(load_val), MAX_COUNT));
  assign at_max = (q_out == MAX_Q);
  assign tc     = at_max;

  // A load in a tick cycle swallows that tick, so loading MAX never carries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_out <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      q_out <= '0;
      carry <= 1'b0;
    end else if (load) begin
      q_out <= load_q;
      carry <= 1'b0;
    end else if (tick) begin
      if (at_max) begin
        q_out <= '0;
        carry <= 1'b1;
      end else begin
        q_out <= q_out + WIDTH'(1);
        carry <= 1'b0;
      end
    end else begin
      carry <= 1'b0;
    end
  end

endmodule
